// File: rtl/npu_pkg.sv
// Shared NPU datapath definitions: default widths, MAC FSM state encoding, u8 clamp.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package npu_pkg;

    localparam int DEF_KERNEL_SIZE  = 3;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_PIXEL_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH    = 20;
    localparam int DEF_NTAPS        = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

    // IDLE: no weights held yet; ACC: consuming window pixels; OUT: result pending.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } mac_state_t;

    // Clamp a signed value into 0..255.
    function automatic logic [7:0] sat_u8(input logic signed [63:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 64'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/mac_requant.sv
// Requantizer: ReLU, arithmetic right shift, saturate to unsigned 8 bits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
// Ports: value (signed ACC_WIDTH accumulator sum) -> q (u8 activation).
module mac_requant
    import npu_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_WIDTH-1:0] value,
    output logic        [7:0]           q
);

    logic signed [63:0] wide;
    logic signed [63:0] relu;
    logic signed [63:0] shifted;

    always_comb begin
        wide    = 64'(value);
        relu    = (wide < 0) ? 64'sd0 : wide;
        shifted = relu >>> OUT_SHIFT;
        q       = sat_u8(shifted);
    end

endmodule

// File: rtl/conv_mac_unit.sv
// Serial KxK convolution MAC: latch one weight set, then one signed dot product per KxK pixel window.
// Latency: result valid 1 cycle after the last pixel handshake; K*K+1 cycles per window.
// Backpressure: o_pix_ready drops while a result waits on i_ready; kernel accepted only at window start.
// Ports: i_clk/i_rst (sync, active-high); i_kernel_load/i_kernel/o_kernel_ready weight latch;
//        i_pix_valid/i_pix/o_pix_ready pixel stream; i_abort window drop;
//        o_valid/i_ready/o_result/o_result_q result channel.
module conv_mac_unit
    import npu_pkg::*;
#(
    parameter  int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter  int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter  int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter  int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter  int OUT_SHIFT    = 0,
    localparam int NTAPS        = KERNEL_SIZE * KERNEL_SIZE
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_kernel_load,
    input  logic [NTAPS*WEIGHT_WIDTH-1:0] i_kernel,
    output logic                          o_kernel_ready,
    input  logic                          i_pix_valid,
    input  logic [PIXEL_WIDTH-1:0]        i_pix,
    output logic                          o_pix_ready,
    input  logic                          i_abort,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [ACC_WIDTH-1:0]   o_result,
    output logic [7:0]                    o_result_q
);

    localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PROD_W = WEIGHT_WIDTH + PIXEL_WIDTH + 1;

    mac_state_t state_q, state_d;

    logic [TAP_W-1:0]               tap_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [WEIGHT_WIDTH-1:0] w_q [NTAPS];

    logic                           tap_last;
    logic                           kernel_take;
    logic                           pix_hs;
    logic                           out_hs;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    sum_next;
    logic [7:0]                     q_next;

    assign tap_last    = (tap_q == TAP_W'(NTAPS - 1));
    assign kernel_take = i_kernel_load && o_kernel_ready;
    assign pix_hs      = i_pix_valid && o_pix_ready;
    assign out_hs      = o_valid && i_ready;

    // Pixel is zero-extended so it multiplies as a non-negative signed operand.
    assign prod     = PROD_W'(w_q[tap_q]) * PROD_W'($signed({1'b0, i_pix}));
    assign sum_next = acc_q + ACC_WIDTH'(prod);

    mac_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_requant (
        .value (sum_next),
        .q     (q_next)
    );

    always_comb begin
        state_d        = state_q;
        o_pix_ready    = 1'b0;
        o_kernel_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_kernel_ready = 1'b1;
                if (i_kernel_load)
                    state_d = ST_ACC;
            end
            ST_ACC: begin
                o_pix_ready    = 1'b1;
                o_kernel_ready = (tap_q == '0);
                if (!i_abort && i_pix_valid && tap_last)
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                if (i_abort || (o_valid && i_ready))
                    state_d = ST_ACC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            tap_q      <= '0;
            acc_q      <= '0;
            o_valid    <= 1'b0;
            o_result   <= '0;
            o_result_q <= '0;
            for (int t = 0; t < NTAPS; t++)
                w_q[t] <= '0;
        end else begin
            state_q <= state_d;

            // A load coinciding with the tap-0 pixel takes effect from tap 1 on;
            // the tap-0 product above already used the old weight.
            if (kernel_take) begin
                for (int t = 0; t < NTAPS; t++)
                    w_q[t] <= i_kernel[t*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end

            case (state_q)
                ST_IDLE: begin
                    if (kernel_take) begin
                        tap_q <= '0;
                        acc_q <= '0;
                    end
                end
                ST_ACC: begin
                    if (i_abort) begin
                        tap_q   <= '0;
                        acc_q   <= '0;
                        o_valid <= 1'b0;
                    end else if (pix_hs) begin
                        if (tap_last) begin
                            o_result   <= sum_next;
                            o_result_q <= q_next;
                            o_valid    <= 1'b1;
                            tap_q      <= '0;
                            acc_q      <= '0;
                        end else begin
                            acc_q <= sum_next;
                            tap_q <= tap_q + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    // Abort takes priority over a same-cycle result handshake.
                    if (i_abort) begin
                        tap_q   <= '0;
                        acc_q   <= '0;
                        o_valid <= 1'b0;
                    end else if (out_hs) begin
                        o_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_unit.sv
module tb_conv_mac_unit;
    import npu_pkg::*;

    localparam int NT = DEF_NTAPS;
    localparam int WW = DEF_WEIGHT_WIDTH;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_kernel_load;
    logic [NT*WW-1:0]       i_kernel;
    logic                   o_kernel_ready;
    logic                   i_pix_valid;
    logic [7:0]             i_pix;
    logic                   o_pix_ready;
    logic                   i_abort;
    logic                   o_valid;
    logic                   i_ready;
    logic signed [19:0]     o_result;
    logic [7:0]             o_result_q;

    int tests = 0;
    int fails = 0;
    int pv [NT];
    int wv [NT];

    always #5 i_clk = ~i_clk;

    conv_mac_unit dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_kernel_load  (i_kernel_load),
        .i_kernel       (i_kernel),
        .o_kernel_ready (o_kernel_ready),
        .i_pix_valid    (i_pix_valid),
        .i_pix          (i_pix),
        .o_pix_ready    (o_pix_ready),
        .i_abort        (i_abort),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_result       (o_result),
        .o_result_q     (o_result_q)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_kernel_all(input int w);
        for (int t = 0; t < NT; t++) i_kernel[t*WW +: WW] = WW'(w);
    endtask

    task automatic load_kernel(input string tag, input int w);
        check({tag, "_kready"}, o_kernel_ready, 1);
        set_kernel_all(w);
        i_kernel_load = 1'b1;
        @(negedge i_clk);
        i_kernel_load = 1'b0;
    endtask

    task automatic send_pixel(input int p, input int gap);
        int n;
        repeat (gap) @(negedge i_clk);
        i_pix_valid = 1'b1;
        i_pix       = 8'(p);
        n = 0;
        while (!o_pix_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) check("pix_ready_timeout", o_pix_ready, 1);
        @(negedge i_clk);
        i_pix_valid = 1'b0;
    endtask

    task automatic send_const(input int p, input int count);
        for (int i = 0; i < count; i++) send_pixel(p, 0);
    endtask

    task automatic expect_result(input string tag, input int r, input int q);
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_result"}, $signed(o_result), r);
        check({tag, "_q"}, o_result_q, q);
        if (i_ready) begin
            @(negedge i_clk);
            check({tag, "_valid_drop"}, o_valid, 0);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_kernel_load = 1'b0; i_kernel = '0; i_pix_valid = 1'b0;
        i_pix = '0; i_abort = 1'b0; i_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // Reset state
        check("rst_valid", o_valid, 0);
        check("rst_pix_ready", o_pix_ready, 0);
        check("rst_kernel_ready", o_kernel_ready, 1);
        check("rst_result", $signed(o_result), 0);
        check("rst_result_q", o_result_q, 0);

        // 1: w=1, pixels 1..9 -> 45
        load_kernel("t1", 1);
        check("t1_pix_ready", o_pix_ready, 1);
        for (int i = 1; i <= 9; i++) send_pixel(i, 0);
        expect_result("t1", 45, 45);

        // 2: w=-128, pixels 255 -> -293760, q=0
        load_kernel("t2", -128);
        send_const(255, 9);
        expect_result("t2", -293760, 0);

        // 3: w=1, pixels 255 -> 2295, q saturates to 255
        load_kernel("t3", 1);
        send_const(255, 9);
        expect_result("t3", 2295, 255);

        // 4: result held under backpressure, then next window
        i_ready = 1'b0;
        send_const(3, 9);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", o_valid, 1);
            check("t4_hold_result", $signed(o_result), 27);
            check("t4_hold_pix_ready", o_pix_ready, 0);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        check("t4_valid_drop", o_valid, 0);
        check("t4_pix_ready_back", o_pix_ready, 1);
        send_const(2, 9);
        expect_result("t4b", 18, 18);

        // 5: load attempted at tap 4 is ignored
        send_const(1, 4);
        check("t5_kready_low", o_kernel_ready, 0);
        set_kernel_all(2);
        i_kernel_load = 1'b1;
        @(negedge i_clk);
        i_kernel_load = 1'b0;
        send_const(1, 5);
        expect_result("t5", 9, 9);

        // 5b: load together with the tap-0 pixel; tap 0 uses old weight 1
        set_kernel_all(3);
        i_kernel_load = 1'b1;
        send_pixel(10, 0);
        i_kernel_load = 1'b0;
        send_const(1, 8);
        expect_result("t5b", 34, 34);

        // 6: abort at tap 6, weights kept
        load_kernel("t6", 1);
        send_const(5, 6);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("t6_abort_valid", o_valid, 0);
        check("t6_abort_kready", o_kernel_ready, 1);
        send_const(1, 9);
        expect_result("t6", 9, 9);

        // 6b: reset at tap 3 clears everything back to IDLE
        send_const(7, 3);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("t6r_pix_ready", o_pix_ready, 0);
        check("t6r_kready", o_kernel_ready, 1);
        check("t6r_result", $signed(o_result), 0);
        check("t6r_valid", o_valid, 0);
        i_pix_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("t6r_idle_pix_ready", o_pix_ready, 0);
        end
        i_pix_valid = 1'b0;
        load_kernel("t6r", 2);
        for (int i = 1; i <= 9; i++) send_pixel(i, 0);
        expect_result("t6r", 90, 90);

        // Random weights/pixels with input gaps and output stalls
        for (int w = 0; w < 12; w++) begin
            int exp_r, exp_q, stall;
            exp_r = 0;
            for (int t = 0; t < NT; t++) begin
                wv[t] = int'($urandom_range(0, 255)) - 128;
                pv[t] = int'($urandom_range(0, 255));
                exp_r += wv[t] * pv[t];
            end
            exp_q = (exp_r < 0) ? 0 : ((exp_r > 255) ? 255 : exp_r);
            check("rnd_kready", o_kernel_ready, 1);
            for (int t = 0; t < NT; t++) i_kernel[t*WW +: WW] = WW'(wv[t]);
            i_kernel_load = 1'b1;
            @(negedge i_clk);
            i_kernel_load = 1'b0;
            i_ready = 1'b0;
            for (int t = 0; t < NT; t++) send_pixel(pv[t], int'($urandom_range(0, 2)));
            expect_result("rnd", exp_r, exp_q);
            stall = int'($urandom_range(0, 3));
            repeat (stall) begin
                @(negedge i_clk);
                check("rnd_hold_valid", o_valid, 1);
            end
            i_ready = 1'b1;
            @(negedge i_clk);
            check("rnd_valid_drop", o_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
